// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a registered 4-to-1 mux stage with a valid/ready output.
// A requester wins when req[i] & gnt[i]; the chosen data appears on out_* one cycle later.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  typedef enum logic [0:0] {StIdle, StFull} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       sel_q;
  logic             valid_q;

  logic             can_load;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             grant_en;
  logic [WIDTH-1:0] mux_data;

  assign can_load = (state_q == StIdle) | out_ready;

  // Scan requesters starting at ptr_q, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // rst_n gating keeps gnt low for the whole time reset is asserted.
  assign grant_en = can_load & found & rst_n;

  always_comb begin
    gnt = 4'b0000;
    if (grant_en) begin
      gnt = 4'b0001 << win;
    end
  end

  always_comb begin
    mux_data = a;
    unique case (win)
      2'd0: mux_data = a;
      2'd1: mux_data = b;
      2'd2: mux_data = c;
      2'd3: mux_data = d;
      default: mux_data = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_en) begin
            state_q <= StFull;
            data_q  <= mux_data;
            sel_q   <= win;
            valid_q <= 1'b1;
            ptr_q   <= win + 2'd1;
          end
        end
        StFull: begin
          if (grant_en) begin
            data_q  <= mux_data;
            sel_q   <= win;
            valid_q <= 1'b1;
            ptr_q   <= win + 2'd1;
          end else if (out_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
